// File: rtl/mem_request_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// mem_request_sequencer_pkg : FSM encoding and default widths
// Rev 1.0
// ============================================================================
package mem_request_sequencer_pkg;

  localparam int DEFAULT_DATA_W     = 8;
  localparam int DEFAULT_ADDR_W     = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ      = 2'd2,
    ST_READ_WAIT = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : power-of-two write buffer, head visible combinationally
// Rev 1.0
// ============================================================================
module sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_idx_q, wr_idx_d;
  logic [PTR_W-1:0]  rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Indices wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_idx_q] = push_data;
      wr_idx_d        = wr_idx_q + 1'b1;
    end
    if (pop) begin
      rd_idx_d = rd_idx_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_idx_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_request_sequencer.sv
`default_nettype none
// ============================================================================
// mem_request_sequencer : arbitrates buffered writes and single reads onto
//                         one memory-controller port
// Rev 1.0
// ============================================================================
module mem_request_sequencer
  import mem_request_sequencer_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk_mem,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W-1:0] wr_ptr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CNT_W-1:0]  fifo_count;

  // Gating with reset keeps wr_ready low while the block is held in reset.
  assign wr_ready  = reset & ~full;
  assign fifo_push = wr_valid & wr_ready;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_mem),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_data_d = rd_data_q;
    rd_ready  = 1'b0;
    rd_valid  = 1'b0;
    mem_w_en  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A full buffer wins over a read; otherwise reads cut in between writes.
        if (full) begin
          state_d = ST_WRITE;
        end else if (rd_req && reset) begin
          state_d   = ST_READ;
          rd_addr_d = rd_addr;
          rd_ready  = 1'b1;
        end else if (!empty) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_w_en  = 1'b1;
        mem_addr  = wr_ptr_q;
        mem_wdata = fifo_head;
        fifo_pop  = 1'b1;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        state_d   = ST_IDLE;
      end
      ST_READ: begin
        mem_addr = rd_addr_q;
        state_d  = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        rd_data_d = mem_rdata;
        rd_valid  = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      wr_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Memory data is live during the valid pulse and held afterwards.
  assign rd_data = rd_valid ? mem_rdata : rd_data_q;
  assign wr_ptr  = wr_ptr_q;

  a_fifo_sane: assert property (@(posedge clk_mem) disable iff (!reset)
    (fifo_count <= CNT_W'(FIFO_DEPTH)) && !(fifo_push && full));

endmodule
`default_nettype wire

// File: tb/tb_mem_request_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mem_request_sequencer : scoreboard bench with table and directed sequences
// Rev 1.0
// ============================================================================
module tb_mem_request_sequencer;

  logic       clk_mem = 1'b0;
  logic       reset   = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       wr_ready;
  logic       rd_req   = 1'b0;
  logic [7:0] rd_addr  = 8'h00;
  logic       rd_ready, rd_valid;
  logic [7:0] rd_data;
  logic       mem_w_en;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       empty, full;
  logic [7:0] wr_ptr;

  always #5 clk_mem = ~clk_mem;

  mem_request_sequencer #(.DATA_W(8), .ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk_mem  (clk_mem),  .reset    (reset),
    .wr_valid (wr_valid), .wr_data  (wr_data),  .wr_ready (wr_ready),
    .rd_req   (rd_req),   .rd_addr  (rd_addr),  .rd_ready (rd_ready),
    .rd_valid (rd_valid), .rd_data  (rd_data),
    .mem_w_en (mem_w_en), .mem_addr (mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .empty    (empty),    .full     (full),     .wr_ptr   (wr_ptr)
  );

  // Memory model: one-cycle registered read.
  logic [7:0] mem_model [256];
  always @(posedge clk_mem) begin
    mem_rdata <= mem_model[mem_addr];
    if (mem_w_en) mem_model[mem_addr] = mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk_mem) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_exp_t;
  typedef struct { logic [7:0] data; int cyc; } rd_exp_t;
  wr_exp_t exp_wr[$];
  rd_exp_t exp_rd[$];
  logic [7:0] exp_ptr = 8'h00;

  always @(negedge clk_mem) begin : monitor
    wr_exp_t we;
    rd_exp_t re;
    if (reset) begin
      if (mem_w_en) begin
        check("write_expected", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          we = exp_wr.pop_front();
          check("wr_addr", mem_addr, we.addr);
          check("wr_data", mem_wdata, we.data);
        end
      end else begin
        check("wdata_zero_outside_write", mem_wdata, 0);
      end
      if (rd_valid) begin
        check("read_expected", 32'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) begin
          re = exp_rd.pop_front();
          check("rd_data", rd_data, re.data);
          check("rd_latency", cyc - re.cyc, 2);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] a, input logic [7:0] d);
    for (int i = 0; i < 100 && !wr_ready; i++) @(negedge clk_mem);
    check("push_ready", wr_ready, 1);
    if (wr_ready) begin
      wr_valid = 1'b1;
      wr_data  = d;
      exp_wr.push_back('{addr: a, data: d});
      @(negedge clk_mem);
      wr_valid = 1'b0;
    end
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] d);
    bit got = 1'b0;
    rd_req  = 1'b1;
    rd_addr = a;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (rd_ready) got = 1'b1;
      else @(negedge clk_mem);
    end
    check("rd_accept", 32'(got), 1);
    if (got) exp_rd.push_back('{data: d, cyc: cyc});
    @(negedge clk_mem);
    rd_req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && !(exp_wr.size() == 0 && exp_rd.size() == 0 && empty); i++)
      @(negedge clk_mem);
    check({name, "_wq_drained"}, exp_wr.size(), 0);
    check({name, "_rq_drained"}, exp_rd.size(), 0);
    check({name, "_empty"}, empty, 1);
  endtask

  typedef struct { logic [7:0] data; logic [7:0] exp_addr; } wr_vec_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; } rd_vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wr_vec_t     wtab [3];
    rd_vec_t     rtab [4];
    logic [7:0]  s3_data [3];
    logic [17:0] got_rdy, got_wen, got_full;
    int          reads_done;

    wtab = '{'{8'hA1, 8'h00}, '{8'hB2, 8'h01}, '{8'hC3, 8'h02}};
    rtab = '{'{8'h05, 8'h5A}, '{8'h10, 8'hC7}, '{8'hFF, 8'h3C}, '{8'h7E, 8'h81}};
    s3_data = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    foreach (rtab[i]) mem_model[rtab[i].addr] = rtab[i].data;
    for (int i = 0; i < 3; i++) mem_model[8'h80 + i] = s3_data[i];
    mem_model[8'h90] = 8'h99;
    mem_model[8'hA0] = 8'h77;

    // Reset values with inputs active
    rd_req = 1'b1; wr_valid = 1'b1;
    @(negedge clk_mem); @(negedge clk_mem);
    check("rst_rd_ready", rd_ready, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_mem_w_en", mem_w_en, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_rd_valid", rd_valid, 0);
    rd_req = 1'b0; wr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk_mem);

    // Three sequential writes from a table
    foreach (wtab[i]) begin
      push_byte(wtab[i].exp_addr, wtab[i].data);
      exp_ptr++;
    end
    wait_drain("s1");
    check("s1_wr_ptr", wr_ptr, 3);

    // Table-driven reads of preloaded locations
    foreach (rtab[i]) do_read(rtab[i].addr, rtab[i].data);
    wait_drain("s2");
    @(negedge clk_mem);
    check("rd_data_hold", rd_data, rtab[3].data);

    // Fill while reads pending: full write preempts the read
    reads_done = 0;
    got_rdy = '0; got_wen = '0; got_full = '0;
    for (int c = 0; c < 18; c++) begin
      wr_valid = (c < 4);
      wr_data  = 8'(8'hD0 + c);
      if (c < 4) begin
        check("s3_wr_ready", wr_ready, 1);
        exp_wr.push_back('{addr: exp_ptr, data: 8'(8'hD0 + c)});
        exp_ptr++;
      end
      rd_req  = (reads_done < 3);
      rd_addr = 8'(8'h80 + reads_done);
      #1;
      got_rdy[c]  = rd_ready;
      got_wen[c]  = mem_w_en;
      got_full[c] = full;
      if (rd_ready) begin
        exp_rd.push_back('{data: s3_data[reads_done], cyc: cyc});
        reads_done++;
      end
      @(negedge clk_mem);
    end
    wr_valid = 1'b0; rd_req = 1'b0;
    check("s3_rd_ready_pattern", 32'(got_rdy), 32'h00109);
    check("s3_w_en_pattern", 32'(got_wen), 32'h15080);
    check("s3_full_pattern", 32'(got_full), 32'h000F0);
    wait_drain("s3");
    check("s3_wr_ptr", wr_ptr, 7);

    // Push and pop in the same cycle at count 2
    rd_req = 1'b1; rd_addr = 8'h90;
    wr_valid = 1'b1; wr_data = 8'hE1;
    exp_wr.push_back('{addr: exp_ptr, data: 8'hE1}); exp_ptr++;
    #1;
    check("s6_rd_ready", rd_ready, 1);
    if (rd_ready) exp_rd.push_back('{data: 8'h99, cyc: cyc});
    @(negedge clk_mem);
    rd_req = 1'b0; wr_data = 8'hE2;
    exp_wr.push_back('{addr: exp_ptr, data: 8'hE2}); exp_ptr++;
    @(negedge clk_mem);
    wr_valid = 1'b0;
    @(negedge clk_mem);
    check("s6_count_before", 32'(dut.u_fifo.count), 2);
    @(negedge clk_mem);
    check("s6_in_write", mem_w_en, 1);
    wr_valid = 1'b1; wr_data = 8'hE3;
    exp_wr.push_back('{addr: exp_ptr, data: 8'hE3}); exp_ptr++;
    @(negedge clk_mem);
    wr_valid = 1'b0;
    check("s6_count_after", 32'(dut.u_fifo.count), 2);
    wait_drain("s6");
    check("s6_wr_ptr", wr_ptr, 10);

    // Reset during READ_WAIT with a byte buffered
    rd_req = 1'b1; rd_addr = 8'hA0;
    wr_valid = 1'b1; wr_data = 8'hF1;
    #1;
    check("s5_rd_ready", rd_ready, 1);
    @(negedge clk_mem);
    rd_req = 1'b0; wr_valid = 1'b0;
    @(posedge clk_mem); #1;
    check("s5_in_read_wait", rd_valid, 1);
    reset = 1'b0;
    rd_req = 1'b1;
    @(negedge clk_mem);
    check("s5_rd_valid", rd_valid, 0);
    check("s5_rd_ready", rd_ready, 0);
    check("s5_rd_data", rd_data, 0);
    check("s5_mem_w_en", mem_w_en, 0);
    check("s5_mem_addr", mem_addr, 0);
    check("s5_mem_wdata", mem_wdata, 0);
    check("s5_empty", empty, 1);
    check("s5_full", full, 0);
    check("s5_wr_ready", wr_ready, 0);
    check("s5_wr_ptr", wr_ptr, 0);
    rd_req = 1'b0;
    reset = 1'b1;
    exp_ptr = 8'h00;
    repeat (5) @(negedge clk_mem);
    check("s5_post_empty", empty, 1);
    check("s5_post_wr_ptr", wr_ptr, 0);

    // 256 writes wrap the pointer; the 257th lands at address 0
    for (int i = 0; i < 256; i++) begin
      push_byte(exp_ptr, 8'(i ^ 8'h5A));
      exp_ptr++;
    end
    wait_drain("s4");
    check("s4_wr_ptr_wrapped", wr_ptr, 0);
    push_byte(8'h00, 8'hEE);
    wait_drain("s4b");
    check("s4_wr_ptr_after", wr_ptr, 1);
    check("s4_mem0", mem_model[0], 8'hEE);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_request_sequencer.md
MEM_REQUEST_SEQUENCER -- requirements
Module: mem_request_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the byte width of write, read and memory data.
REQ-002 Parameter ADDR_W, default 8, SHALL set the memory address width; the address space is 2^ADDR_W words.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the write-buffer depth; it SHALL be a power of two, 2..16.
REQ-004 Port list SHALL be exactly as follows; the design has one clock, and reset is asynchronous and active-low.
- clk_mem  in  1  single clock; all state SHALL change on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr_valid  in  1  upstream write byte valid.
- wr_data  in  DATA_W  upstream write byte.
- wr_ready  out  1  write buffer can accept a byte.
- rd_req  in  1  read request.
- rd_addr  in  ADDR_W  read request address.
- rd_ready  out  1  read request accepted this cycle.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  DATA_W  read result, held until the next rd_valid.
- mem_w_en  out  1  memory-controller write enable (1 = write, 0 = read).
- mem_addr  out  ADDR_W  memory-controller address.
- mem_wdata  out  DATA_W  memory-controller write data.
- mem_rdata  in  DATA_W  memory-controller read data, valid 1 cycle after the address is presented.
- empty  out  1  write buffer empty.
- full  out  1  write buffer full.
- wr_ptr  out  ADDR_W  next sequential write address.

Function
REQ-005 The FIFO SHALL push when wr_valid && wr_ready; wr_ready SHALL equal !full, computed from the registered count.
REQ-006 A push and a pop in the same cycle SHALL leave the count unchanged; a push while full SHALL never occur.
REQ-007 The FSM SHALL have four states: IDLE, WRITE, READ, READ_WAIT; the reset state is IDLE.
REQ-008 IDLE transitions SHALL be, in priority order:
- full -> WRITE;
- rd_req -> READ, latching rd_addr and pulsing rd_ready for 1 cycle;
- !empty -> WRITE;
- otherwise stay in IDLE.
REQ-009 rd_ready SHALL be asserted only in IDLE on the cycle the READ transition is taken.
REQ-010 In WRITE the block SHALL, for one cycle:
- drive mem_w_en=1, mem_addr=wr_ptr, mem_wdata=FIFO head;
- pop the head and increment wr_ptr modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0);
- then return to IDLE.
REQ-011 In READ the block SHALL drive mem_w_en=0 and mem_addr=latched address, then go to READ_WAIT.
REQ-012 In READ_WAIT the block SHALL capture mem_rdata into rd_data, pulse rd_valid, and return to IDLE; read latency from rd_ready to rd_valid is 2 cycles.
REQ-013 Outside WRITE, mem_w_en SHALL be 0 and mem_wdata SHALL be 0.
REQ-014 rd_req present while the FSM is not in IDLE SHALL be ignored; the requester holds rd_req until rd_ready.
REQ-015 A write burst SHALL yield to a pending read after each single write unless the FIFO is full.

Reset
REQ-016 On reset=0, the block SHALL asynchronously clear:
- state=IDLE, FIFO count and pointers=0, wr_ptr=0;
- rd_data=0, rd_valid=0, rd_ready=0, mem_w_en=0, mem_addr=0, mem_wdata=0;
- empty=1, full=0, wr_ready=0 while reset is asserted.
REQ-017 Reset asserted mid-WRITE or mid-READ SHALL abort the operation; buffered bytes SHALL be discarded and no rd_valid SHALL be produced.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding (2-bit) and the default width constants.
REQ-019 The write buffer SHALL be a separate sub-module, sync_fifo, with push/pop/full/empty/count ports.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Push 0xA1, 0xB2, 0xC3 -> mem writes to addresses 0, 1, 2 in order; wr_ptr=3; empty=1 afterwards.
- With addr 0x05 preloaded with 0x5A, rd_req with rd_addr=0x05 -> rd_ready, then 2 cycles later rd_valid=1 with rd_data=0x5A, mem_w_en=0 throughout.
- Fill 4 bytes while a read is requested -> FIFO-full write taken first, then the read, then the remaining writes; full deasserts after the first pop.
- Write 256 bytes -> wr_ptr wraps 0xFF -> 0x00; the 257th byte is written to address 0.
- Assert reset during READ_WAIT -> no rd_valid; all outputs are at reset values on the next cycle.
- Push and pop in the same cycle at count=2 -> count stays 2; no byte is lost or duplicated.
